// File: rtl/riscv_structures.sv
// Shared pipeline enums: hazard-unit operand source and pipeline control state.
package riscv_structures;

  typedef enum logic [1:0] {
    HU_NONE = 2'd0,
    HU_EX   = 2'd1,
    HU_MEM  = 2'd2,
    HU_WB   = 2'd3
  } hu_src_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (inc && cnt != '1)    cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, EX redirects and
// multi-cycle mul/div waits with timeout abort, plus perf counters.
module pipe_ctrl
  import riscv_structures::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hu_stall,
  input  logic             ex_redirect,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MDW = $clog2(MD_TIMEOUT + 1);
  localparam logic [MDW-1:0] TMO_LAST = MDW'(MD_TIMEOUT - 1);

  pipe_state_e    state, state_nx;
  logic [MDW-1:0] md_cnt;
  logic           stall, redirect, abort, md_clr, md_inc;

  always_comb begin
    stall    = 1'b0;
    redirect = 1'b0;
    abort    = 1'b0;
    md_clr   = 1'b0;
    md_inc   = 1'b0;
    state_nx = RUN;
    case (state)
      MD_WAIT: begin
        if (!md_done) begin
          if (md_cnt == TMO_LAST) abort = 1'b1;
          else begin
            stall    = 1'b1;
            md_inc   = 1'b1;
            state_nx = MD_WAIT;
          end
        end
      end
      default: begin
        // LU_STALL ignores hu_stall: the operand now forwards from WB.
        if (state == RUN && hu_stall) begin
          stall    = 1'b1;
          state_nx = LU_STALL;
        end else if (ex_redirect) begin
          redirect = 1'b1;
        end else if (md_start) begin
          stall    = 1'b1;
          md_clr   = 1'b1;
          state_nx = MD_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    pc_we         = !stall;
    if_id_we      = !stall;
    id_ex_we      = !stall;
    pc_sel        = redirect;
    if_id_flush   = redirect;
    id_ex_flush   = redirect | abort;
    ex_mem_bubble = stall | abort;
    if (!rst_n) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      pc_sel        = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
      md_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (md_clr)      md_cnt <= '0;
      else if (md_inc) md_cnt <= md_cnt + MDW'(1);
      if (abort)       md_err <= 1'b1;
    end
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_we),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .clear (1'b0),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and small timeout/width) driven
// in lockstep, checked against a rule-level reference model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0, hu_stall = 1'b0, ex_redirect = 1'b0, md_start = 1'b0, md_done = 1'b0;

  logic        pc_we_a, pc_sel_a, if_id_we_a, id_ex_we_a, if_id_flush_a, id_ex_flush_a, ex_mem_bubble_a, md_err_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic        pc_we_b, pc_sel_b, if_id_we_b, id_ex_we_b, if_id_flush_b, id_ex_flush_b, ex_mem_bubble_b, md_err_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_TIMEOUT(40), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .hu_stall(hu_stall), .ex_redirect(ex_redirect),
    .md_start(md_start), .md_done(md_done), .pc_we(pc_we_a), .pc_sel(pc_sel_a),
    .if_id_we(if_id_we_a), .id_ex_we(id_ex_we_a), .if_id_flush(if_id_flush_a),
    .id_ex_flush(id_ex_flush_a), .ex_mem_bubble(ex_mem_bubble_a), .md_err(md_err_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_ctrl #(.MD_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .hu_stall(hu_stall), .ex_redirect(ex_redirect),
    .md_start(md_start), .md_done(md_done), .pc_we(pc_we_b), .pc_sel(pc_sel_b),
    .if_id_we(if_id_we_b), .id_ex_we(id_ex_we_b), .if_id_flush(if_id_flush_b),
    .id_ex_flush(id_ex_flush_b), .ex_mem_bubble(ex_mem_bubble_b), .md_err(md_err_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // Expected output bundles: {pc_we, pc_sel, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_bubble}
  localparam logic [6:0] O_NORM  = 7'b1011000;
  localparam logic [6:0] O_STALL = 7'b0000001;
  localparam logic [6:0] O_REDIR = 7'b1111110;
  localparam logic [6:0] O_ABORT = 7'b1011011;
  localparam logic [6:0] O_RST   = 7'b0000111;

  typedef struct {
    bit     shadow;   // previous cycle was a load-use stall
    bit     busy;     // mul/div outstanding
    bit     err;
    int     waited;
    longint st;
    longint fl;
  } mdl_t;

  mdl_t ma, mb;
  int n_vec = 0, n_mis = 0;

  function automatic logic [6:0] step(inout mdl_t m, input int tmo, input longint cap,
                                      input bit hs, input bit rd, input bit ms, input bit md);
    logic [6:0] e;
    bit was_shadow;
    was_shadow = m.shadow;
    m.shadow   = 1'b0;
    e          = O_NORM;
    if (m.busy) begin
      if (md) m.busy = 1'b0;
      else if (m.waited == tmo - 1) begin
        e = O_ABORT; m.err = 1'b1; m.busy = 1'b0;
      end else begin
        e = O_STALL; m.waited++;
      end
    end else if (hs && !was_shadow) begin
      e = O_STALL; m.shadow = 1'b1;
    end else if (rd) begin
      e = O_REDIR;
      if (m.fl < cap) m.fl++;
    end else if (ms) begin
      e = O_STALL; m.busy = 1'b1; m.waited = 0;
    end
    if (!e[6] && m.st < cap) m.st++;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rs, input bit hs, input bit rd, input bit ms, input bit md);
    mdl_t na, nb;
    logic [6:0] ea, eb;
    @(negedge clk);
    rst_n = rs; hu_stall = hs; ex_redirect = rd; md_start = ms; md_done = md;
    if (!rs) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end
    na = ma; nb = mb;
    ea = rs ? step(na, 40, 64'hFFFF_FFFF, hs, rd, ms, md) : O_RST;
    eb = rs ? step(nb, 4, 15, hs, rd, ms, md) : O_RST;
    #1;
    chk("outs_a", 64'({pc_we_a, pc_sel_a, if_id_we_a, id_ex_we_a, if_id_flush_a, id_ex_flush_a, ex_mem_bubble_a}), 64'(ea));
    chk("outs_b", 64'({pc_we_b, pc_sel_b, if_id_we_b, id_ex_we_b, if_id_flush_b, id_ex_flush_b, ex_mem_bubble_b}), 64'(eb));
    chk("stall_cnt_a", 64'(stall_cnt_a), 64'(ma.st));
    chk("flush_cnt_a", 64'(flush_cnt_a), 64'(ma.fl));
    chk("md_err_a", 64'(md_err_a), 64'(ma.err));
    chk("stall_cnt_b", 64'(stall_cnt_b), 64'(mb.st));
    chk("flush_cnt_b", 64'(flush_cnt_b), 64'(mb.fl));
    chk("md_err_b", 64'(md_err_b), 64'(mb.err));
    @(posedge clk);
    ma = na; mb = nb;
    #1;
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset held with hu_stall high, then two stall requests in a row.
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("rst_then_lu_stall_cnt", 64'(stall_cnt_a), 64'd1);

    // Stall beats redirect, redirect honoured the cycle after.
    cyc(1, 1, 1, 0, 0);
    chk("stall_wins_flush_cnt", 64'(flush_cnt_a), 64'd0);
    cyc(1, 0, 1, 0, 0);
    chk("redirect_flush_cnt", 64'(flush_cnt_a), 64'd1);
    chk("redirect_stall_cnt", 64'(stall_cnt_a), 64'd2);

    // md_start then md_done five cycles later; small instance times out.
    cyc(1, 0, 0, 1, 0);
    repeat (4) cyc(1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 1);
    chk("md_done_stall_cnt_a", 64'(stall_cnt_a), 64'd7);
    chk("md_done_err_a", 64'(md_err_a), 64'd0);
    chk("md_timeout_stall_cnt_b", 64'(stall_cnt_b), 64'd6);
    chk("md_timeout_err_b", 64'(md_err_b), 64'd1);

    // Never-ending mul/div: b aborts again, a waits until released.
    cyc(1, 0, 0, 1, 0);
    repeat (7) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("md_err_sticky_b", 64'(md_err_b), 64'd1);

    // 20 redirects saturate the 4-bit flush counter.
    repeat (20) cyc(1, 0, 1, 0, 0);
    chk("flush_cnt_sat_b", 64'(flush_cnt_b), 64'd15);
    chk("flush_cnt_a_21", 64'(flush_cnt_a), 64'd21);

    // Reset mid-wait aborts without setting md_err.
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (6) cyc(1, 0, 0, 0, 0);
    chk("rst_mid_wait_err_b", 64'(md_err_b), 64'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(99) != 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom_range(4) == 0, $urandom_range(2) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
